// File: rtl/nf_rule_serializer_pkg.sv
// Shared types and constants for the non-fast-pattern rule serializer:
// packet metadata layout, stats register map and FSM state encoding.
package nf_rule_serializer_pkg;

  localparam int RULE_W_DEF = 16;
  localparam int SLOTS_DEF  = 32;

  typedef struct packed {
    logic [15:0] flow_id;
    logic [15:0] pkt_len;
    logic [31:0] timestamp;
  } metadata_t;

  localparam logic [7:0] REG_NF_SER_PKT  = 8'h00;
  localparam logic [7:0] REG_NF_SER_RULE = 8'h04;
  localparam logic [7:0] REG_NF_SER_ZERO = 8'h08;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SCAN,
    FLUSH,
    ZERO,
    META
  } ser_state_t;

endpackage

// File: rtl/nf_rule_serializer_ffs_32.sv
// Lowest-set-bit priority encoder over a 32-bit vector; bit 0 wins.
module ffs_32 (
  input  logic [31:0] vec,
  output logic        found,
  output logic [4:0]  idx
);

  always_comb begin
    found = |vec;
    idx   = '0;
    for (int k = 31; k >= 0; k--) begin
      if (vec[k]) idx = 5'(k);
    end
  end

endmodule

// File: rtl/nf_rule_serializer.sv
// Turns 512-bit rule-slot frames into a stream of one rule ID per beat,
// followed by the packet's metadata, keeping one rule frame per metadata beat.
module nf_rule_serializer
  import nf_rule_serializer_pkg::*;
#(
  parameter int RULE_W = RULE_W_DEF,
  parameter int SLOTS  = SLOTS_DEF
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic                    in_meta_valid,
  output logic                    in_meta_ready,
  input  logic [$bits(metadata_t)-1:0] in_meta_data,
  input  logic                    in_usr_valid,
  output logic                    in_usr_ready,
  input  logic [RULE_W*SLOTS-1:0] in_usr_data,
  input  logic                    in_usr_eop,
  output logic                    out_meta_valid,
  input  logic                    out_meta_ready,
  output logic [$bits(metadata_t)-1:0] out_meta_data,
  output logic                    out_rule_valid,
  input  logic                    out_rule_ready,
  output logic [RULE_W-1:0]       out_rule_data,
  output logic                    out_rule_sop,
  output logic                    out_rule_eop,
  output logic                    out_rule_empty,
  input  logic                    stats_wr,
  input  logic [7:0]              stats_addr,
  input  logic [31:0]             stats_wdata,
  output logic [31:0]             stats_in_pkt,
  output logic [31:0]             stats_out_rule,
  output logic [31:0]             stats_zero_rule_pkt
);

  localparam int BEAT_W = RULE_W * SLOTS;
  localparam logic [SLOTS-1:0] ONE_HOT0 = {{(SLOTS-1){1'b0}}, 1'b1};

  ser_state_t              state;
  logic [$bits(metadata_t)-1:0] meta_q;
  logic [BEAT_W-1:0]       beat_q;
  logic [SLOTS-1:0]        mask;
  logic [SLOTS-1:0]        nz_mask;
  logic                    eop_q;
  logic                    first_flag;
  logic                    pend_valid;
  logic [RULE_W-1:0]       pend_data;
  logic                    pend_first;
  logic                    found;
  logic [4:0]              slot_idx;
  logic [RULE_W-1:0]       sel_rule;
  logic                    out_free;

  ffs_32 u_ffs (
    .vec   (mask),
    .found (found),
    .idx   (slot_idx)
  );

  // Slot 0 sits in the most significant RULE_W bits of the beat.
  always_comb begin
    nz_mask  = '0;
    sel_rule = '0;
    for (int k = 0; k < SLOTS; k++) begin
      nz_mask[k] = |in_usr_data[BEAT_W-1-RULE_W*k -: RULE_W];
      if (slot_idx == 5'(k)) sel_rule = beat_q[BEAT_W-1-RULE_W*k -: RULE_W];
    end
  end

  assign out_free       = !out_rule_valid || out_rule_ready;
  assign out_meta_data  = meta_q;
  assign out_rule_empty = 1'b0;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state               <= IDLE;
      meta_q              <= '0;
      beat_q              <= '0;
      mask                <= '0;
      eop_q               <= 1'b0;
      first_flag          <= 1'b0;
      pend_valid          <= 1'b0;
      pend_data           <= '0;
      pend_first          <= 1'b0;
      in_meta_ready       <= 1'b0;
      in_usr_ready        <= 1'b0;
      out_meta_valid      <= 1'b0;
      out_rule_valid      <= 1'b0;
      out_rule_data       <= '0;
      out_rule_sop        <= 1'b0;
      out_rule_eop        <= 1'b0;
      stats_in_pkt        <= '0;
      stats_out_rule      <= '0;
      stats_zero_rule_pkt <= '0;
    end else begin
      if (out_rule_valid && out_rule_ready) begin
        out_rule_valid <= 1'b0;
        if (out_rule_data != '0) stats_out_rule <= stats_out_rule + 32'd1;
      end

      case (state)
        IDLE: begin
          if (in_meta_valid && in_meta_ready) begin
            meta_q        <= in_meta_data;
            in_meta_ready <= 1'b0;
            in_usr_ready  <= 1'b1;
            first_flag    <= 1'b1;
            state         <= LOAD;
          end else begin
            in_meta_ready <= 1'b1;
          end
        end

        LOAD: begin
          if (in_usr_valid && in_usr_ready) begin
            beat_q       <= in_usr_data;
            mask         <= nz_mask;
            eop_q        <= in_usr_eop;
            in_usr_ready <= 1'b0;
            state        <= SCAN;
          end
        end

        // A rule only leaves the pending slot once a newer one shows up, so
        // the last rule of a frame is still held when we learn it carries eop.
        SCAN: begin
          if (found) begin
            if (!pend_valid || out_free) begin
              if (pend_valid) begin
                out_rule_valid <= 1'b1;
                out_rule_data  <= pend_data;
                out_rule_sop   <= pend_first;
                out_rule_eop   <= 1'b0;
              end
              pend_valid <= 1'b1;
              pend_data  <= sel_rule;
              pend_first <= first_flag;
              first_flag <= 1'b0;
              mask       <= mask & ~(ONE_HOT0 << slot_idx);
            end
          end else if (!eop_q) begin
            in_usr_ready <= 1'b1;
            state        <= LOAD;
          end else if (pend_valid) begin
            state <= FLUSH;
          end else begin
            state <= ZERO;
          end
        end

        FLUSH: begin
          if (out_free) begin
            out_rule_valid <= 1'b1;
            out_rule_data  <= pend_data;
            out_rule_sop   <= pend_first;
            out_rule_eop   <= 1'b1;
            pend_valid     <= 1'b0;
            out_meta_valid <= 1'b1;
            state          <= META;
          end
        end

        // A packet with no rules still gets a single all-zero rule beat so
        // every metadata beat has exactly one matching rule frame.
        ZERO: begin
          if (out_free) begin
            out_rule_valid      <= 1'b1;
            out_rule_data       <= '0;
            out_rule_sop        <= 1'b1;
            out_rule_eop        <= 1'b1;
            stats_zero_rule_pkt <= stats_zero_rule_pkt + 32'd1;
            out_meta_valid      <= 1'b1;
            state               <= META;
          end
        end

        META: begin
          if (out_meta_valid && out_meta_ready) begin
            out_meta_valid <= 1'b0;
            stats_in_pkt   <= stats_in_pkt + 32'd1;
            in_meta_ready  <= 1'b1;
            state          <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase

      // Software preload takes priority over the running increment.
      if (stats_wr) begin
        case (stats_addr)
          REG_NF_SER_PKT:  stats_in_pkt        <= stats_wdata;
          REG_NF_SER_RULE: stats_out_rule      <= stats_wdata;
          REG_NF_SER_ZERO: stats_zero_rule_pkt <= stats_wdata;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nf_rule_serializer.sv
// Scoreboard bench for nf_rule_serializer: expected rule beats and metadata
// are derived from the slot contents of each frame and checked by a monitor.
module tb_nf_rule_serializer;

  typedef struct packed {
    logic [15:0] data;
    logic        sop;
    logic        eop;
  } rule_beat_t;

  logic         Clk = 1'b0;
  logic         Rst_n = 1'b0;
  logic         in_meta_valid = 1'b0;
  logic         in_meta_ready;
  logic [63:0]  in_meta_data = '0;
  logic         in_usr_valid = 1'b0;
  logic         in_usr_ready;
  logic [511:0] in_usr_data = '0;
  logic         in_usr_eop = 1'b0;
  logic         out_meta_valid;
  logic         out_meta_ready = 1'b0;
  logic [63:0]  out_meta_data;
  logic         out_rule_valid;
  logic         out_rule_ready = 1'b0;
  logic [15:0]  out_rule_data;
  logic         out_rule_sop;
  logic         out_rule_eop;
  logic         out_rule_empty;
  logic         stats_wr = 1'b0;
  logic [7:0]   stats_addr = '0;
  logic [31:0]  stats_wdata = '0;
  logic [31:0]  stats_in_pkt;
  logic [31:0]  stats_out_rule;
  logic [31:0]  stats_zero_rule_pkt;

  int           checks = 0;
  int           failures = 0;
  rule_beat_t   exp_rules[$];
  logic [63:0]  exp_meta[$];
  logic [511:0] pkt_beats[$];
  logic [31:0]  model_pkt = '0;
  logic [31:0]  model_rule = '0;
  logic [31:0]  model_zero = '0;
  int           rules_seen = 0;
  bit           in_reset = 1'b1;
  int           ready_mode = 0;
  bit           stall_pend = 1'b0;
  logic [17:0]  stall_val = '0;

  always #5 Clk = ~Clk;

  nf_rule_serializer dut (
    .Clk                 (Clk),
    .Rst_n               (Rst_n),
    .in_meta_valid       (in_meta_valid),
    .in_meta_ready       (in_meta_ready),
    .in_meta_data        (in_meta_data),
    .in_usr_valid        (in_usr_valid),
    .in_usr_ready        (in_usr_ready),
    .in_usr_data         (in_usr_data),
    .in_usr_eop          (in_usr_eop),
    .out_meta_valid      (out_meta_valid),
    .out_meta_ready      (out_meta_ready),
    .out_meta_data       (out_meta_data),
    .out_rule_valid      (out_rule_valid),
    .out_rule_ready      (out_rule_ready),
    .out_rule_data       (out_rule_data),
    .out_rule_sop        (out_rule_sop),
    .out_rule_eop        (out_rule_eop),
    .out_rule_empty      (out_rule_empty),
    .stats_wr            (stats_wr),
    .stats_addr          (stats_addr),
    .stats_wdata         (stats_wdata),
    .stats_in_pkt        (stats_in_pkt),
    .stats_out_rule      (stats_out_rule),
    .stats_zero_rule_pkt (stats_zero_rule_pkt)
  );

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic report_fail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s", name);
  endtask

  // Output ready patterns: 0 always ready, 1 toggling rule ready, 2 random.
  initial forever begin
    @(posedge Clk);
    #1;
    case (ready_mode)
      0: begin out_rule_ready = 1'b1; out_meta_ready = 1'b1; end
      1: begin out_rule_ready = ~out_rule_ready; out_meta_ready = 1'b1; end
      default: begin
        out_rule_ready = 1'($urandom_range(0, 1));
        out_meta_ready = 1'($urandom_range(0, 1));
      end
    endcase
  end

  // Monitor: a handshake seen mid-cycle completes at the next rising edge.
  initial forever begin
    @(negedge Clk);
    if (in_reset) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) begin
        check_output("rule_valid_held", 64'(out_rule_valid), 64'd1);
        check_output("rule_stable", 64'({out_rule_data, out_rule_sop, out_rule_eop}), 64'(stall_val));
      end
      if (out_rule_valid && out_rule_ready) begin
        if (exp_rules.size() == 0) begin
          report_fail($sformatf("rule_unexpected data=0x%0h", out_rule_data));
        end else begin
          rule_beat_t e;
          e = exp_rules.pop_front();
          check_output("rule_beat", 64'({out_rule_data, out_rule_sop, out_rule_eop, out_rule_empty}),
                       64'({e, 1'b0}));
          rules_seen++;
        end
      end
      stall_pend = out_rule_valid && !out_rule_ready;
      stall_val  = {out_rule_data, out_rule_sop, out_rule_eop};
      if (out_meta_valid && out_meta_ready) begin
        if (exp_meta.size() == 0) report_fail($sformatf("meta_unexpected data=0x%0h", out_meta_data));
        else check_output("meta_data", out_meta_data, exp_meta.pop_front());
      end
    end
  end

  task automatic wait_in_ready(input bit usr);
    int to;
    to = 0;
    forever begin
      @(negedge Clk);
      if (usr ? in_usr_ready : in_meta_ready) break;
      to++;
      if (to > 2000) begin
        report_fail(usr ? "usr_ready_timeout" : "meta_ready_timeout");
        break;
      end
    end
    @(posedge Clk);
    #1;
  endtask

  // Reference model: every non-zero slot in frame order, or one empty beat.
  task automatic apply_stimulus(input logic [63:0] meta);
    int n;
    logic [511:0] beat;
    logic [15:0] v;
    rule_beat_t rb;
    n = 0;
    foreach (pkt_beats[b]) begin
      beat = pkt_beats[b];
      for (int k = 0; k < 32; k++) begin
        v = beat[511-16*k -: 16];
        if (v != 16'd0) begin
          rb.data = v;
          rb.sop  = (n == 0);
          rb.eop  = 1'b0;
          exp_rules.push_back(rb);
          n++;
        end
      end
    end
    if (n == 0) begin
      rb.data = '0; rb.sop = 1'b1; rb.eop = 1'b1;
      exp_rules.push_back(rb);
      model_zero = model_zero + 32'd1;
    end else begin
      exp_rules[exp_rules.size()-1].eop = 1'b1;
    end
    model_rule = model_rule + 32'(n);
    model_pkt  = model_pkt + 32'd1;
    exp_meta.push_back(meta);

    @(posedge Clk);
    #1;
    in_meta_valid = 1'b1;
    in_meta_data  = meta;
    wait_in_ready(1'b0);
    in_meta_valid = 1'b0;
    foreach (pkt_beats[b]) begin
      in_usr_valid = 1'b1;
      in_usr_data  = pkt_beats[b];
      in_usr_eop   = (b == pkt_beats.size() - 1);
      wait_in_ready(1'b1);
      in_usr_valid = 1'b0;
    end
  endtask

  task automatic check_stats(input string tag);
    check_output({tag, "_pkt"}, 64'(stats_in_pkt), 64'(model_pkt));
    check_output({tag, "_rule"}, 64'(stats_out_rule), 64'(model_rule));
    check_output({tag, "_zero"}, 64'(stats_zero_rule_pkt), 64'(model_zero));
  endtask

  task automatic drain(input string tag);
    int to;
    to = 0;
    while ((exp_rules.size() != 0 || exp_meta.size() != 0) && to < 5000) begin
      @(negedge Clk);
      to++;
    end
    if (exp_rules.size() != 0 || exp_meta.size() != 0)
      report_fail($sformatf("%s_drain_timeout rules_left=%0d meta_left=%0d", tag, exp_rules.size(), exp_meta.size()));
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check_stats(tag);
  endtask

  task automatic do_reset(input string tag);
    @(posedge Clk);
    #1;
    in_reset      = 1'b1;
    Rst_n         = 1'b0;
    in_meta_valid = 1'b0;
    in_usr_valid  = 1'b0;
    stats_wr      = 1'b0;
    exp_rules.delete();
    exp_meta.delete();
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    model_pkt = '0; model_rule = '0; model_zero = '0;
    check_output({tag, "_rule_valid"}, 64'(out_rule_valid), 64'd0);
    check_output({tag, "_meta_valid"}, 64'(out_meta_valid), 64'd0);
    check_output({tag, "_meta_ready"}, 64'(in_meta_ready), 64'd0);
    check_output({tag, "_usr_ready"}, 64'(in_usr_ready), 64'd0);
    check_output({tag, "_rule_data"}, 64'(out_rule_data), 64'd0);
    check_stats(tag);
    @(posedge Clk);
    #1;
    Rst_n    = 1'b1;
    in_reset = 1'b0;
  endtask

  task automatic write_stat(input logic [7:0] addr, input logic [31:0] data);
    @(posedge Clk);
    #1;
    stats_wr    = 1'b1;
    stats_addr  = addr;
    stats_wdata = data;
    @(posedge Clk);
    #1;
    stats_wr = 1'b0;
  endtask

  function automatic logic [511:0] put_slot(input logic [511:0] beat, input int k, input logic [15:0] v);
    logic [511:0] r;
    r = beat;
    r[511-16*k -: 16] = v;
    return r;
  endfunction

  initial begin
    logic [511:0] beat;
    int base;
    int to;

    do_reset("reset");

    // Rules at slots 0, 5 and 31 of one beat.
    ready_mode = 0;
    beat = put_slot('0, 0, 16'h0011);
    beat = put_slot(beat, 5, 16'h0022);
    beat = put_slot(beat, 31, 16'h0033);
    pkt_beats = '{beat};
    apply_stimulus(64'h1111_2222_3333_4444);
    drain("three_rules");

    // Single rule in the first of three beats.
    pkt_beats = '{put_slot('0, 3, 16'h0101), 512'd0, 512'd0};
    apply_stimulus(64'hA5A5_0000_5A5A_FFFF);
    drain("sparse_frame");

    // Frame without any rules.
    pkt_beats = '{512'd0, 512'd0};
    apply_stimulus(64'h0BAD_F00D_1234_5678);
    drain("zero_frame");

    // Full beat under a toggling ready.
    ready_mode = 1;
    beat = '0;
    for (int k = 0; k < 32; k++) beat = put_slot(beat, k, 16'(16'h0200 + k));
    pkt_beats = '{beat};
    apply_stimulus(64'hFEED_BEEF_0000_0032);
    drain("full_toggle");

    // Reset partway through a 32-rule frame, then a clean 2-rule packet.
    ready_mode = 0;
    pkt_beats = '{beat};
    base = rules_seen;
    apply_stimulus(64'h0000_0000_DEAD_0001);
    to = 0;
    while (rules_seen < base + 10 && to < 1000) begin
      @(negedge Clk);
      to++;
    end
    if (rules_seen < base + 10) report_fail("midframe_wait_timeout");
    do_reset("midframe_reset");
    pkt_beats = '{put_slot(put_slot('0, 7, 16'h0777), 20, 16'h0888)};
    apply_stimulus(64'h0000_0000_C0DE_0002);
    drain("after_reset");

    // Counter wrap from all-ones.
    write_stat(8'h00, 32'hFFFF_FFFF);
    write_stat(8'h04, 32'hFFFF_FFFF);
    write_stat(8'h08, 32'hFFFF_FFFF);
    @(negedge Clk);
    model_pkt = 32'hFFFF_FFFF; model_rule = 32'hFFFF_FFFF; model_zero = 32'hFFFF_FFFF;
    check_stats("preload");
    pkt_beats = '{put_slot('0, 12, 16'h4242)};
    apply_stimulus(64'h0000_0000_0000_0034);
    pkt_beats = '{512'd0};
    apply_stimulus(64'h0000_0000_0000_0035);
    drain("wrap");

    // Random frames under random backpressure.
    ready_mode = 2;
    for (int p = 0; p < 25; p++) begin
      int nb;
      nb = $urandom_range(1, 3);
      pkt_beats.delete();
      for (int b = 0; b < nb; b++) begin
        beat = '0;
        if ($urandom_range(0, 3) != 0) begin
          for (int k = 0; k < 32; k++)
            if ($urandom_range(0, 5) == 0) beat = put_slot(beat, k, 16'($urandom_range(1, 16'hFFFF)));
        end
        pkt_beats.push_back(beat);
      end
      apply_stimulus({$urandom, $urandom});
    end
    drain("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nf_rule_serializer.md
NF_RULE_SERIALIZER -- requirements
Module: nf_rule_serializer

Interface
REQ-001 SHALL have parameter RULE_W, default 16, meaning rule-ID width in bits.
REQ-002 SHALL have parameter SLOTS, default 32, meaning rule slots per 512-bit input beat (RULE_W*SLOTS = 512).
REQ-003 SHALL have ports: Clk in 1 clock; Rst_n in 1 reset, synchronous, active-low.
REQ-004 SHALL have in_meta, avl_stream_if.rx, width $bits(metadata_t), carrying one beat per packet, from the non-fast-pattern stage output.
REQ-005 SHALL have in_usr, avl_stream_if.rx, width 512, carrying a sop/eop-framed rule frame per packet; slot k = data[511-16k -: 16]; value 0 = empty slot.
REQ-006 SHALL have out_meta, avl_stream_if.tx, width $bits(metadata_t), carrying metadata passed through unchanged.
REQ-007 SHALL have out_rule, avl_stream_if.tx, width RULE_W, carrying one rule ID per beat, sop/eop framed, with empty = 0.
REQ-008 SHALL have outputs stats_in_pkt, stats_out_rule and stats_zero_rule_pkt, each 32 bits, for packets consumed, rules emitted and packets with no rules.

Function
REQ-009 SHALL use FSM states IDLE, LOAD, SCAN, FLUSH, ZERO, META.
REQ-010 IDLE: when in_meta.valid, SHALL capture data, assert in_meta.ready for exactly that cycle, then go to LOAD.
REQ-011 LOAD: in_usr.ready=1 only in LOAD; on valid, SHALL latch the beat, build nz_mask[k]=(slot k!=0), latch eop, then go to SCAN.
REQ-012 SCAN: SHALL select the lowest-index set bit per cycle (slot 0 first) and clear it once it moves into the pending register; it SHALL advance only when the pending register is free or being emitted that cycle.
REQ-013 Pending register: SHALL hold one rule ID plus first flag; a pending rule SHALL be emitted with eop=0 only when a newer rule is found.
REQ-014 When mask empty and latched eop=0: SHALL go to LOAD; an all-zero beat SHALL cost exactly 1 SCAN cycle.
REQ-015 When mask empty and eop=1: SHALL go to FLUSH if a rule is pending, otherwise go to ZERO.
REQ-016 FLUSH: SHALL emit the pending rule with eop=1 (sop=1 if it was the first rule), then go to META.
REQ-017 ZERO: SHALL emit one beat with data=0, sop=1, eop=1, increment stats_zero_rule_pkt, then go to META; this preserves 1:1 frame/meta pairing.
REQ-018 META: SHALL assert out_meta.valid with the captured data; on ready, SHALL go to IDLE and increment stats_in_pkt.
REQ-019 Outputs SHALL be registered; data/sop/eop SHALL be stable while valid && !ready; valid SHALL NOT depend combinationally on ready.
REQ-020 Beat order: out_rule order SHALL equal in_usr slot order across beats; no dedup, no reordering.
REQ-021 stats_out_rule SHALL increment per accepted non-zero out_rule beat; all counters SHALL wrap at 2^32 silently.
REQ-022 Input sop on a beat in LOAD other than the first of a frame SHALL be ignored; framing SHALL be taken from the eop flag only.
REQ-023 Throughput SHALL be 1 rule/cycle sustained under continuous ready; per-packet overhead SHALL be 3 cycles (IDLE, LOAD, META).

Reset
REQ-024 On Rst_n=0 at posedge Clk: FSM SHALL go to IDLE; all valid/ready SHALL be 0; pending, mask and counters SHALL be 0; out data SHALL be 0.
REQ-025 Reset mid-frame SHALL drop the partial frame with no eop emitted; the first packet after reset SHALL start cleanly with sop.

Structure
REQ-026 metadata_t and the stats register addresses (REG_NF_SER_PKT, REG_NF_SER_RULE, REG_NF_SER_ZERO) SHALL live in the shared struct package; RULE_W/SLOTS defaults SHALL be package constants.
REQ-027 The lowest-set-bit priority encoder SHALL be one sub-module, ffs_32.
REQ-028 RTL size SHALL be 120-400 lines.

Verification
REQ-029 One 512-bit beat with rules at slots 0,5,31 = 0x0011,0x0022,0x0033, sop/eop, ready=1 -> out_rule 0x0011(sop),0x0022,0x0033(eop), then one out_meta equal to input; stats_out_rule=3.
REQ-030 Three-beat frame, rule 0x0101 at slot 3 of beat 0 only, beats 1-2 all zero -> single out_rule 0x0101 with sop=eop=1.
REQ-031 Frame of two all-zero beats -> one beat data=0 sop=eop=1; stats_zero_rule_pkt=1.
REQ-032 32 non-zero slots, out_rule.ready toggling 1/0 each cycle -> 32 beats in order, data stable during stalls, exactly one eop.
REQ-033 Assert Rst_n=0 after 10 of 32 rules emitted, then send a 2-rule packet -> outputs idle during reset; next frame begins sop, 2 beats; counters restart from 0.
REQ-034 Counter preloaded to 0xFFFFFFFF, one packet processed -> counter reads 0.
